ascii_ps2_tx: RTL

- Keyboard-side PS/2 transmitter: the opposite direction of the scan-code-to-ASCII lookup path.
- Accepts one ASCII character per handshake, maps it to PS/2 scan-code set 2, and serialises a full keystroke onto ps2_clk/ps2_data: optional shift make, key make, key break (F0 + key), optional shift break.
- Used as a synthesizable keyboard emulator to drive the PS/2 receiver and keyboard decoding path in simulation and on board.

---
 rtl/ascii_ps2_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ascii_ps2_tx.sv
// Keyboard-side PS/2 transmitter: maps an ASCII byte to set-2 scan codes and
// serialises make/break frames (with shift wrapping for capitals) onto ps2_clk/ps2_data.
module ascii_ps2_tx #(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ascii_valid,
  input  logic [7:0] ascii_data,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       err
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRAME, S_GAP, S_DONE, S_ERR} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   half_cnt, half_cnt_n;
  logic            phase, phase_n;
  logic [3:0]      bit_idx, bit_idx_n;
  logic [2:0]      byte_idx, byte_idx_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic [7:0]      char_q;
  logic [7:0]      tx_byte, tx_byte_n;
  logic [7:0]      map_in;
  logic [7:0]      key_code;
  logic            key_ok;
  logic            shift;
  logic [7:0]      seq_byte;
  logic [2:0]      last_idx;
  logic [10:0]     frame_word;
  logic            clk_n;
  logic            data_n;

  // Returns {mapped, shift, scan_code}; capitals fold onto the lowercase key.
  function automatic logic [9:0] map_ascii(input logic [7:0] c);
    logic [7:0] lc;
    logic [7:0] k;
    logic       ok;
    logic       up;
    up = (c >= 8'h41) && (c <= 8'h5A);
    lc = up ? (c | 8'h20) : c;
    ok = 1'b1;
    k  = 8'h00;
    case (lc)
      8'h61: k = 8'h1C;  8'h62: k = 8'h32;  8'h63: k = 8'h21;  8'h64: k = 8'h23;
      8'h65: k = 8'h24;  8'h66: k = 8'h2B;  8'h67: k = 8'h34;  8'h68: k = 8'h33;
      8'h69: k = 8'h43;  8'h6A: k = 8'h3B;  8'h6B: k = 8'h42;  8'h6C: k = 8'h4B;
      8'h6D: k = 8'h3A;  8'h6E: k = 8'h31;  8'h6F: k = 8'h44;  8'h70: k = 8'h4D;
      8'h71: k = 8'h15;  8'h72: k = 8'h2D;  8'h73: k = 8'h1B;  8'h74: k = 8'h2C;
      8'h75: k = 8'h3C;  8'h76: k = 8'h2A;  8'h77: k = 8'h1D;  8'h78: k = 8'h22;
      8'h79: k = 8'h35;  8'h7A: k = 8'h1A;
      8'h30: k = 8'h45;  8'h31: k = 8'h16;  8'h32: k = 8'h1E;  8'h33: k = 8'h26;
      8'h34: k = 8'h25;  8'h35: k = 8'h2E;  8'h36: k = 8'h36;  8'h37: k = 8'h3D;
      8'h38: k = 8'h3E;  8'h39: k = 8'h46;
      8'h20: k = 8'h29;  8'h0A: k = 8'h5A;  8'h08: k = 8'h66;
      default: ok = 1'b0;
    endcase
    return {ok, up & ok, k};
  endfunction

  // Byte n of the keystroke: [12] K F0 K [F0 12].
  function automatic logic [7:0] seq_sel(input logic [2:0] idx, input logic sh,
                                         input logic [7:0] k);
    logic [7:0] b;
    b = 8'hF0;
    if (sh) begin
      case (idx)
        3'd0:    b = 8'h12;
        3'd1:    b = k;
        3'd2:    b = 8'hF0;
        3'd3:    b = k;
        3'd4:    b = 8'hF0;
        3'd5:    b = 8'h12;
        default: b = 8'hF0;
      endcase
    end else begin
      case (idx)
        3'd0:    b = k;
        3'd1:    b = 8'hF0;
        3'd2:    b = k;
        default: b = 8'hF0;
      endcase
    end
    return b;
  endfunction

  // While idle the live input is classified so err can fire the cycle after acceptance.
  assign map_in                      = (state == S_IDLE) ? ascii_data : char_q;
  assign {key_ok, shift, key_code}   = map_ascii(map_in);
  assign seq_byte                    = seq_sel(byte_idx, shift, key_code);
  assign last_idx                    = shift ? 3'd5 : 3'd2;
  assign tx_byte_n                   = (state == S_LOAD) ? seq_byte : tx_byte;
  assign frame_word                  = {1'b1, ~^tx_byte_n, tx_byte_n, 1'b0};

  // LOAD doubles as the first high-phase cycle of the start bit.
  always_comb begin
    state_n    = state;
    half_cnt_n = half_cnt;
    phase_n    = phase;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    gap_cnt_n  = gap_cnt;
    case (state)
      S_IDLE: begin
        if (ascii_valid) begin
          state_n = key_ok ? S_LOAD : S_ERR;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD, S_FRAME: begin
        state_n = S_FRAME;
        if (half_cnt == CW'(CLK_DIV - 1)) begin
          half_cnt_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (bit_idx == 4'd10) begin
              bit_idx_n = 4'd0;
              state_n   = S_GAP;
            end else begin
              bit_idx_n = bit_idx + 4'd1;
            end
          end
        end else begin
          half_cnt_n = half_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          gap_cnt_n = '0;
          if (byte_idx == last_idx) begin
            byte_idx_n = 3'd0;
            state_n    = S_DONE;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
            state_n    = S_LOAD;
          end
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    clk_n  = 1'b1;
    data_n = 1'b1;
    if (state_n == S_LOAD || state_n == S_FRAME) begin
      clk_n  = ~phase_n;
      data_n = frame_word[bit_idx_n];
    end else begin
      clk_n  = 1'b1;
      data_n = 1'b1;
    end
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      half_cnt    <= '0;
      phase       <= 1'b0;
      bit_idx     <= 4'd0;
      byte_idx    <= 3'd0;
      gap_cnt     <= '0;
      char_q      <= 8'h00;
      tx_byte     <= 8'h00;
      ascii_ready <= 1'b1;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      half_cnt    <= half_cnt_n;
      phase       <= phase_n;
      bit_idx     <= bit_idx_n;
      byte_idx    <= byte_idx_n;
      gap_cnt     <= gap_cnt_n;
      tx_byte     <= tx_byte_n;
      if (state == S_IDLE && ascii_valid) begin
        char_q <= ascii_data;
      end else begin
        char_q <= char_q;
      end
      ascii_ready <= (state_n == S_IDLE);
      ps2_clk     <= clk_n;
      ps2_data    <= data_n;
      err         <= (state_n == S_ERR);
    end
  end

endmodule
